id_stage: RTL and testbench

- Decode stage of the 5-stage LA32R pipeline (IF -> ID -> EX -> MEM -> WB); sits directly downstream of the fetch stage.
- Latches {pc, inst} from fetch and decodes a fixed integer subset.
- Reads the internal 32x32 register file, with forwarding from EX/MEM/WB and a load-use interlock.
- Resolves branches and jumps in ID and returns the redirect to fetch on the branch bus.

---
 rtl/id_stage.sv | 166 ++++++++++++++++
 tb/tb_id_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage LA32R pipeline.
//   Latches {pc, inst} from fetch, decodes an integer subset, reads the
//   internal 32x32 register file with EX/MEM/WB forwarding and a load-use
//   interlock, and resolves branches/jumps back to fetch.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   IF_to_ID_valid/BUS incoming {pc, inst} from fetch
//   ID_allowin         ID can take a new instruction this cycle
//   BR_BUS             {br_target, br_taken, br_taken_cancel} to fetch
//   EX_allowin         EX accepts this cycle
//   ID_to_EX_valid/BUS decoded instruction to EX
//   EX_fwd_BUS         {valid, gr_we, is_load, dest, result} from EX
//   MEM_fwd_BUS        {valid, gr_we, dest, result} from MEM
//   WB_rf_BUS          {rf_we, rf_waddr, rf_wdata}, also the regfile write port
module id_stage #(
   parameter int IF_TO_ID_LEN = 63,
   parameter int BR_BUS_LEN   = 33,
   parameter int ID_TO_EX_LEN = 147
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    IF_to_ID_valid,
   input  logic [IF_TO_ID_LEN:0]   IF_to_ID_BUS,
   output logic                    ID_allowin,
   output logic [BR_BUS_LEN:0]     BR_BUS,
   input  logic                    EX_allowin,
   output logic                    ID_to_EX_valid,
   output logic [ID_TO_EX_LEN:0]   ID_to_EX_BUS,
   input  logic [39:0]             EX_fwd_BUS,
   input  logic [38:0]             MEM_fwd_BUS,
   input  logic [37:0]             WB_rf_BUS
);

   logic        id_valid_q;
   logic [31:0] id_pc_q, id_inst_q;
   logic [31:0] rf_q [32];

   // ---------------- decode ----------------
   logic [4:0] rj, rk, rd, rkd_addr, dest;
   assign rj = id_inst_q[9:5];
   assign rk = id_inst_q[14:10];
   assign rd = id_inst_q[4:0];

   logic [16:0] op17;
   logic [9:0]  op10;
   logic [6:0]  op7;
   logic [5:0]  op6;
   assign op17 = id_inst_q[31:15];
   assign op10 = id_inst_q[31:22];
   assign op7  = id_inst_q[31:25];
   assign op6  = id_inst_q[31:26];

   logic i_add, i_sub, i_slt, i_sltu, i_and, i_or, i_nor, i_xor;
   logic i_slli, i_srli, i_srai, i_addi, i_lu12i, i_ld, i_st;
   logic i_beq, i_bne, i_b, i_bl, i_jirl;
   assign i_add   = op17 == 17'h00020;
   assign i_sub   = op17 == 17'h00022;
   assign i_slt   = op17 == 17'h00024;
   assign i_sltu  = op17 == 17'h00025;
   assign i_nor   = op17 == 17'h00028;
   assign i_and   = op17 == 17'h00029;
   assign i_or    = op17 == 17'h0002A;
   assign i_xor   = op17 == 17'h0002B;
   assign i_slli  = op17 == 17'h00081;
   assign i_srli  = op17 == 17'h00089;
   assign i_srai  = op17 == 17'h00091;
   assign i_addi  = op10 == 10'h00A;
   assign i_ld    = op10 == 10'h0A2;
   assign i_st    = op10 == 10'h0A6;
   assign i_lu12i = op7  == 7'h0A;
   assign i_jirl  = op6  == 6'h13;
   assign i_b     = op6  == 6'h14;
   assign i_bl    = op6  == 6'h15;
   assign i_beq   = op6  == 6'h16;
   assign i_bne   = op6  == 6'h17;

   logic is_3r, is_shi, is_si12, is_link, rd_is_src, use_rj, use_rkd;
   assign is_3r     = i_add | i_sub | i_slt | i_sltu | i_and | i_or | i_nor | i_xor;
   assign is_shi    = i_slli | i_srli | i_srai;
   assign is_si12   = i_addi | i_ld | i_st;
   assign is_link   = i_bl | i_jirl;
   assign rd_is_src = i_beq | i_bne | i_st;
   assign use_rj    = is_3r | is_shi | is_si12 | i_beq | i_bne | i_jirl;
   assign use_rkd   = is_3r | rd_is_src;
   assign rkd_addr  = rd_is_src ? rd : rk;
   assign dest      = i_bl ? 5'd1 : rd;

   // ---------------- operand fetch with forwarding ----------------
   logic        ex_act, mem_act, wb_act;
   logic [4:0]  ex_dest, mem_dest, wb_addr;
   assign ex_dest  = EX_fwd_BUS[36:32];
   assign mem_dest = MEM_fwd_BUS[36:32];
   assign wb_addr  = WB_rf_BUS[36:32];
   assign ex_act   = EX_fwd_BUS[39] & EX_fwd_BUS[38] & (ex_dest != 5'd0);
   assign mem_act  = MEM_fwd_BUS[38] & MEM_fwd_BUS[37] & (mem_dest != 5'd0);
   assign wb_act   = WB_rf_BUS[37] & (wb_addr != 5'd0);

   logic ex_hit_j, ex_hit_k;
   logic [31:0] rj_val, rkd_val;
   assign ex_hit_j = ex_act & (ex_dest == rj);
   assign ex_hit_k = ex_act & (ex_dest == rkd_addr);

   // WB hit doubles as the regfile write-through path.
   always_comb begin
      rj_val = (rj == 5'd0) ? 32'd0 : rf_q[rj];
      if (ex_hit_j)                          rj_val = EX_fwd_BUS[31:0];
      else if (mem_act && mem_dest == rj)    rj_val = MEM_fwd_BUS[31:0];
      else if (wb_act && wb_addr == rj)      rj_val = WB_rf_BUS[31:0];
      rkd_val = (rkd_addr == 5'd0) ? 32'd0 : rf_q[rkd_addr];
      if (ex_hit_k)                             rkd_val = EX_fwd_BUS[31:0];
      else if (mem_act && mem_dest == rkd_addr) rkd_val = MEM_fwd_BUS[31:0];
      else if (wb_act && wb_addr == rkd_addr)   rkd_val = WB_rf_BUS[31:0];
   end

   // A load in EX cannot forward yet; only operands the instruction uses stall.
   logic ready_go;
   assign ready_go = !(EX_fwd_BUS[37] & ((use_rj & ex_hit_j) | (use_rkd & ex_hit_k)));

   assign ID_allowin     = !id_valid_q || (ready_go && EX_allowin);
   assign ID_to_EX_valid = id_valid_q && ready_go;

   // ---------------- branch resolution ----------------
   logic        br_cond, br_taken;
   logic [31:0] br_offs, br_target;
   assign br_cond  = (i_beq & (rj_val == rkd_val)) | (i_bne & (rj_val != rkd_val)) |
                     i_b | i_bl | i_jirl;
   assign br_taken = id_valid_q & ready_go & EX_allowin & br_cond;
   assign br_offs  = (i_b | i_bl) ?
                     {{4{id_inst_q[9]}}, id_inst_q[9:0], id_inst_q[25:10], 2'b00} :
                     {{14{id_inst_q[25]}}, id_inst_q[25:10], 2'b00};
   assign br_target = (i_jirl ? rj_val : id_pc_q) + br_offs;
   assign BR_BUS    = br_taken ? {br_target, 1'b1, 1'b1} : '0;

   // ---------------- outputs to EX ----------------
   logic [11:0] alu_op;
   logic [31:0] src1, src2;
   logic        gr_we;
   assign alu_op = {i_lu12i, i_srai, i_srli, i_slli, i_xor, i_or, i_nor, i_and,
                    i_sltu, i_slt, i_sub, i_add | is_si12 | is_link};
   assign src1   = is_link ? id_pc_q : rj_val;
   always_comb begin
      src2 = rkd_val;
      if (is_link)      src2 = 32'd4;
      else if (is_si12) src2 = {{20{id_inst_q[21]}}, id_inst_q[21:10]};
      else if (is_shi)  src2 = {27'd0, id_inst_q[14:10]};
      else if (i_lu12i) src2 = {id_inst_q[24:5], 12'd0};
   end
   assign gr_we = (is_3r | is_shi | i_addi | i_lu12i | i_ld | is_link) & (dest != 5'd0);
   assign ID_to_EX_BUS = {alu_op, src1, src2, rkd_val, i_st, i_ld, gr_we, dest, id_pc_q};

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         // A taken branch kills whatever fetch presents this cycle.
         if (ID_allowin) id_valid_q <= IF_to_ID_valid && !br_taken;
         if (IF_to_ID_valid && ID_allowin) {id_pc_q, id_inst_q} <= IF_to_ID_BUS;
         if (wb_act) rf_q[wb_addr] <= WB_rf_BUS[31:0];
      end
   end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         resetn, IF_to_ID_valid, EX_allowin;
   logic [63:0]  IF_to_ID_BUS;
   logic         ID_allowin, ID_to_EX_valid;
   logic [33:0]  BR_BUS;
   logic [147:0] ID_to_EX_BUS;
   logic [39:0]  ex_f;
   logic [38:0]  mem_f;
   logic [37:0]  wb_f;

   id_stage dut (
      .clk(clk), .resetn(resetn), .IF_to_ID_valid(IF_to_ID_valid),
      .IF_to_ID_BUS(IF_to_ID_BUS), .ID_allowin(ID_allowin), .BR_BUS(BR_BUS),
      .EX_allowin(EX_allowin), .ID_to_EX_valid(ID_to_EX_valid),
      .ID_to_EX_BUS(ID_to_EX_BUS), .EX_fwd_BUS(ex_f), .MEM_fwd_BUS(mem_f),
      .WB_rf_BUS(wb_f)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction encoders ----------------
   localparam logic [31:0] OP_ADD = 32'h00100000, OP_SUB = 32'h00110000,
      OP_SLT = 32'h00120000, OP_SLTU = 32'h00128000, OP_NOR = 32'h00140000,
      OP_AND = 32'h00148000, OP_OR = 32'h00150000, OP_XOR = 32'h00158000,
      OP_SLLI = 32'h00408000, OP_SRLI = 32'h00448000, OP_SRAI = 32'h00488000,
      OP_ADDI = 32'h02800000, OP_LD = 32'h28800000, OP_ST = 32'h29800000;

   function automatic logic [31:0] r3(input logic [31:0] base, input logic [4:0] d, j, k);
      return base | {17'd0, k, j, d};
   endfunction
   function automatic logic [31:0] ri12(input logic [31:0] base, input logic [4:0] d, j,
                                        input logic [11:0] imm);
      return base | {10'd0, imm, j, d};
   endfunction
   function automatic logic [31:0] br16(input logic [5:0] op, input logic [4:0] j, d,
                                        input logic [15:0] off);
      return {op, off, j, d};
   endfunction
   function automatic logic [31:0] br26(input logic [5:0] op, input logic [25:0] off);
      return {op, off[15:0], off[25:16]};
   endfunction

   // ---------------- reference model ----------------
   typedef enum {K_ADD, K_SUB, K_SLT, K_SLTU, K_AND, K_NOR, K_OR, K_XOR,
                 K_SLLI, K_SRLI, K_SRAI, K_ADDI, K_LU12I, K_LD, K_ST,
                 K_BEQ, K_BNE, K_B, K_BL, K_JIRL, K_NOP} kind_t;

   function automatic kind_t kind_of(input logic [31:0] i);
      case (i & 32'hFFFF8000)
         OP_ADD: return K_ADD;   OP_SUB: return K_SUB;
         OP_SLT: return K_SLT;   OP_SLTU: return K_SLTU;
         OP_AND: return K_AND;   OP_NOR: return K_NOR;
         OP_OR:  return K_OR;    OP_XOR: return K_XOR;
         OP_SLLI: return K_SLLI; OP_SRLI: return K_SRLI;
         OP_SRAI: return K_SRAI;
         default: ;
      endcase
      case (i & 32'hFFC00000)
         OP_ADDI: return K_ADDI; OP_LD: return K_LD; OP_ST: return K_ST;
         default: ;
      endcase
      if ((i & 32'hFE000000) == 32'h14000000) return K_LU12I;
      case (i & 32'hFC000000)
         32'h4C000000: return K_JIRL; 32'h50000000: return K_B;
         32'h54000000: return K_BL;   32'h58000000: return K_BEQ;
         32'h5C000000: return K_BNE;
         default: ;
      endcase
      return K_NOP;
   endfunction

   logic        m_valid;
   logic [31:0] m_pc, m_inst;
   logic [31:0] m_rf [32];

   // Architectural value of register a as seen this cycle.
   function automatic logic [31:0] opnd(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (ex_f[39] && ex_f[38] && ex_f[36:32] == a) return ex_f[31:0];
      if (mem_f[38] && mem_f[37] && mem_f[36:32] == a) return mem_f[31:0];
      if (wb_f[37] && wb_f[36:32] == a) return wb_f[31:0];
      return m_rf[a];
   endfunction
   function automatic bit load_in_ex(input logic [4:0] a);
      return a != 0 && ex_f[39] && ex_f[38] && ex_f[37] && ex_f[36:32] == a;
   endfunction

   logic         s_allow, s_valid;
   logic [33:0]  s_br;
   logic [147:0] s_bus;

   task automatic check_cycle();
      kind_t k;
      logic [4:0] rj, rk, rd, sec, e_dest;
      logic [31:0] v1, v2, tgt, e_src2;
      logic [11:0] e_alu;
      bit is3r, uses_j, uses_k, stall, e_allow, e_valid, jump, e_taken, chk_alu, chk_src2, writes;
      int off;
      k  = kind_of(m_inst);
      rj = m_inst[9:5]; rk = m_inst[14:10]; rd = m_inst[4:0];
      is3r   = k inside {K_ADD, K_SUB, K_SLT, K_SLTU, K_AND, K_NOR, K_OR, K_XOR};
      sec    = (k inside {K_BEQ, K_BNE, K_ST}) ? rd : rk;
      v1 = opnd(rj); v2 = opnd(sec);
      uses_j = !(k inside {K_LU12I, K_B, K_BL, K_NOP});
      uses_k = is3r || (k inside {K_BEQ, K_BNE, K_ST});
      stall  = (uses_j && load_in_ex(rj)) || (uses_k && load_in_ex(sec));
      e_allow = !m_valid || (!stall && EX_allowin);
      e_valid = m_valid && !stall;
      jump = (k inside {K_B, K_BL, K_JIRL}) || (k == K_BEQ && v1 == v2) || (k == K_BNE && v1 != v2);
      e_taken = e_valid && EX_allowin && jump;
      if (k == K_B || k == K_BL) begin
         off = $signed({m_inst[9:0], m_inst[25:10]});
      end else begin
         off = $signed(m_inst[25:10]);
      end
      off = off * 4;
      tgt = ((k == K_JIRL) ? v1 : m_pc) + 32'(off);

      chk("allowin", ID_allowin, e_allow);
      chk("to_ex_valid", ID_to_EX_valid, e_valid);
      chk("br_bus", BR_BUS, e_taken ? {tgt, 2'b11} : 34'd0);

      if (e_valid && ID_to_EX_valid) begin
         chk_alu = 1; chk_src2 = 1; e_alu = '0; e_src2 = v2;
         case (k)
            K_ADD, K_ADDI, K_LD, K_ST, K_BL, K_JIRL: e_alu = 12'h001;
            K_SUB: e_alu = 12'h002;  K_SLT: e_alu = 12'h004;  K_SLTU: e_alu = 12'h008;
            K_AND: e_alu = 12'h010;  K_NOR: e_alu = 12'h020;  K_OR: e_alu = 12'h040;
            K_XOR: e_alu = 12'h080;  K_SLLI: e_alu = 12'h100; K_SRLI: e_alu = 12'h200;
            K_SRAI: e_alu = 12'h400; K_LU12I: e_alu = 12'h800;
            default: chk_alu = 0;
         endcase
         case (k)
            K_SLLI, K_SRLI, K_SRAI: e_src2 = {27'd0, m_inst[14:10]};
            K_ADDI, K_LD, K_ST: begin off = $signed(m_inst[21:10]); e_src2 = 32'(off); end
            K_LU12I: e_src2 = {m_inst[24:5], 12'd0};
            K_BL, K_JIRL: e_src2 = 32'd4;
            default: chk_src2 = is3r;
         endcase
         e_dest = (k == K_BL) ? 5'd1 : rd;
         writes = is3r || (k inside {K_SLLI, K_SRLI, K_SRAI, K_ADDI, K_LU12I, K_LD, K_BL, K_JIRL});
         chk("pc", ID_to_EX_BUS[31:0], m_pc);
         chk("src1", ID_to_EX_BUS[135:104], (k == K_BL || k == K_JIRL) ? m_pc : v1);
         if (chk_src2) chk("src2", ID_to_EX_BUS[103:72], e_src2);
         chk("rkd_value", ID_to_EX_BUS[71:40], v2);
         chk("mem_we", ID_to_EX_BUS[39], k == K_ST);
         chk("res_from_mem", ID_to_EX_BUS[38], k == K_LD);
         chk("gr_we", ID_to_EX_BUS[37], writes && e_dest != 0);
         chk("dest", ID_to_EX_BUS[36:32], e_dest);
         if (chk_alu) chk("alu_op", ID_to_EX_BUS[147:136], e_alu);
      end

      s_allow = ID_allowin; s_valid = ID_to_EX_valid; s_br = BR_BUS; s_bus = ID_to_EX_BUS;

      // advance the model to the state after the coming edge
      if (!resetn) begin
         m_valid = 0; m_pc = 0; m_inst = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 0;
      end else begin
         if (e_allow) begin
            m_valid = IF_to_ID_valid && !e_taken;
            if (IF_to_ID_valid) {m_pc, m_inst} = IF_to_ID_BUS;
         end
         if (wb_f[37] && wb_f[36:32] != 0) m_rf[wb_f[36:32]] = wb_f[31:0];
      end
   endtask

   task automatic step(input logic rn, ifv, input logic [31:0] pc, inst, input logic exa,
                       input logic [39:0] exf, input logic [38:0] memf, input logic [37:0] wbf);
      resetn = rn; IF_to_ID_valid = ifv; IF_to_ID_BUS = {pc, inst};
      EX_allowin = exa; ex_f = exf; mem_f = memf; wb_f = wbf;
      @(negedge clk);
      check_cycle();
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] d, j, k;
      d = 5'($urandom_range(0, 3)); j = 5'($urandom_range(0, 3)); k = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 20))
         0: return r3(OP_ADD, d, j, k);   1: return r3(OP_SUB, d, j, k);
         2: return r3(OP_SLT, d, j, k);   3: return r3(OP_SLTU, d, j, k);
         4: return r3(OP_AND, d, j, k);   5: return r3(OP_NOR, d, j, k);
         6: return r3(OP_OR, d, j, k);    7: return r3(OP_XOR, d, j, k);
         8: return r3(OP_SLLI, d, j, k);  9: return r3(OP_SRLI, d, j, k);
         10: return r3(OP_SRAI, d, j, k);
         11: return ri12(OP_ADDI, d, j, 12'($urandom));
         12: return ri12(OP_LD, d, j, 12'($urandom));
         13: return ri12(OP_ST, d, j, 12'($urandom));
         14: return {7'h0A, 20'($urandom), d};
         15: return br16(6'h16, j, d, 16'($urandom));
         16: return br16(6'h17, j, d, 16'($urandom));
         17: return br26(6'h14, 26'($urandom));
         18: return br26(6'h15, 26'($urandom));
         19: return br16(6'h13, j, d, 16'($urandom));
         default: return {6'h3F, 26'($urandom)};
      endcase
   endfunction

   initial begin
      m_valid = 0; m_pc = 0; m_inst = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      resetn = 0; IF_to_ID_valid = 0; IF_to_ID_BUS = 0; EX_allowin = 1;
      ex_f = 0; mem_f = 0; wb_f = 0;
      @(posedge clk); #1;

      repeat (3) step(0, 0, 0, 0, 1, 0, 0, 0);
      chk("reset_valid", s_valid, 0);
      chk("reset_br", s_br, 0);
      chk("reset_allowin", s_allow, 1);

      // addi.w r1,r0,5
      step(1, 1, 32'h1C000000, ri12(OP_ADDI, 1, 0, 12'd5), 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("addi_valid", s_valid, 1);
      chk("addi_src1", s_bus[135:104], 0);
      chk("addi_src2", s_bus[103:72], 5);
      chk("addi_dest", s_bus[36:32], 1);
      chk("addi_gr_we", s_bus[37], 1);
      chk("addi_alu", s_bus[147:136], 12'h001);

      // add.w r2,r1,r1 with EX/MEM/WB all producing r1
      step(1, 1, 32'h1C000004, r3(OP_ADD, 2, 1, 1), 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, {3'b110, 5'd1, 32'h11}, {2'b11, 5'd1, 32'h22}, {1'b1, 5'd1, 32'h33});
      chk("fwd_src1", s_bus[135:104], 32'h11);
      chk("fwd_src2", s_bus[103:72], 32'h11);

      // sub.w r4,r3,r0 behind a load to r3
      step(1, 1, 32'h1C000008, r3(OP_SUB, 4, 3, 0), 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, {3'b111, 5'd3, 32'hDEAD}, 0, 0);
      chk("lu_valid", s_valid, 0);
      chk("lu_allowin", s_allow, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("lu_issue", s_valid, 1);
      chk("lu_pc", s_bus[31:0], 32'h1C000008);

      // beq r0,r0,+8: wrong-path fetch dropped
      step(1, 1, 32'h1C000010, br16(6'h16, 0, 0, 16'd8), 1, 0, 0, 0);
      step(1, 1, 32'h1C000014, ri12(OP_ADDI, 5, 0, 12'd9), 1, 0, 0, 0);
      chk("beq_br", s_br, {32'h1C000030, 2'b11});
      step(1, 1, 32'h1C000030, ri12(OP_ADDI, 5, 0, 12'd7), 1, 0, 0, 0);
      chk("beq_kill", s_valid, 0);
      chk("beq_br_once", s_br, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("beq_next_pc", s_bus[31:0], 32'h1C000030);

      // jirl r0,r1,0 held by EX_allowin=0
      step(1, 1, 32'h1C000034, br16(6'h13, 1, 0, 16'd0), 1, 0, 0, {1'b1, 5'd1, 32'h1C000100});
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jirl_hold1", s_br, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jirl_hold2", s_br, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("jirl_br", s_br, {32'h1C000100, 2'b11});

      // bl +4
      step(1, 1, 32'h1C000020, br26(6'h15, 26'd4), 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("bl_dest", s_bus[36:32], 1);
      chk("bl_src1", s_bus[135:104], 32'h1C000020);
      chk("bl_src2", s_bus[103:72], 4);
      chk("bl_br", s_br, {32'h1C000030, 2'b11});

      // reset while stalled
      step(1, 1, 32'h1C000040, r3(OP_SUB, 4, 3, 0), 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, {3'b111, 5'd3, 32'h0}, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("rst_mid_valid", s_valid, 0);
      chk("rst_mid_allowin", s_allow, 1);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         logic [39:0] exr; logic [38:0] memr; logic [37:0] wbr;
         exr  = ($urandom_range(0, 2) == 0) ?
                {1'b1, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)} : 40'd0;
         memr = ($urandom_range(0, 2) == 0) ?
                {1'b1, 1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)} : 39'd0;
         wbr  = ($urandom_range(0, 1) == 0) ?
                {1'($urandom), 5'($urandom_range(0, 4)), 32'($urandom)} : 38'd0;
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
              {$urandom} & 32'hFFFFFFFC, rand_inst(), ($urandom_range(0, 4) != 0),
              exr, memr, wbr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
